// File: rtl/result_serializer.sv
// result_serializer: streams an NxN result matrix (N clamped to 4) to a UART, one byte at a time, MSB first.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle frame request, honoured only when idle
//   matrix_size  matrix dimension N, sampled when start is accepted
//   rd_addr      result memory read address (row-major word index)
//   rd_data      result memory data, valid one cycle after rd_addr
//   tx_busy      UART busy, from the slower baud domain
//   tx_data      byte presented to the UART
//   tx_start     one-cycle transmit request
//   busy         high while a frame is in progress
//   done         one-cycle pulse at frame completion
module result_serializer #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);
  localparam int BYTES = WORD_W / 8;
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int MAXW = 2 ** ADDR_W;
  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_TXD, NEXT, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] idx, idx_inc, total, total_c;
  logic [BW-1:0] bcnt;
  logic [WORD_W-1:0] shift;
  logic [2:0] n_c;
  logic last_byte, last_word;
  // word count saturates at the memory depth so the index can never wrap
  always_comb begin
    n_c = matrix_size > 4'd4 ? 3'd4 : matrix_size[2:0];
    total_c = int'(n_c) * int'(n_c) > MAXW ? (ADDR_W+1)'(MAXW) : (ADDR_W+1)'(int'(n_c) * int'(n_c));
    idx_inc = idx + (ADDR_W+1)'(1);
    last_byte = bcnt == BW'(BYTES - 1);
    last_word = idx_inc == total;
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? (n_c == 3'd0 ? FIN : READ) : IDLE;
      READ:     state_nx = LATCH;
      LATCH:    state_nx = SEND;
      SEND:     state_nx = tx_busy ? SEND : WAIT_ACK;
      WAIT_ACK: state_nx = tx_busy ? WAIT_TXD : WAIT_ACK;
      WAIT_TXD: state_nx = tx_busy ? WAIT_TXD : (last_byte ? NEXT : SEND);
      NEXT:     state_nx = last_word ? FIN : READ;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == FIN;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rd_addr <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      idx <= '0;
      total <= '0;
      bcnt <= '0;
      shift <= '0;
    end else begin
      state <= state_nx;
      tx_start <= state == SEND && !tx_busy;
      if (state == IDLE && start) begin
        total <= total_c;
        idx <= '0;
        bcnt <= '0;
      end
      // address is loaded on entry so READ presents it and LATCH sees the data
      if (state_nx == READ) rd_addr <= state == IDLE ? '0 : idx_inc[ADDR_W-1:0];
      if (state == LATCH) shift <= rd_data;
      if (state == SEND && !tx_busy) tx_data <= shift[WORD_W-1 -: 8];
      if (state == WAIT_TXD && !tx_busy && !last_byte) begin
        shift <= shift << 8;
        bcnt <= bcnt + BW'(1);
      end
      if (state == NEXT) begin
        idx <= idx_inc;
        bcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed bench with a byte-queue model of the frame and a UART handshake model.
module tb_result_serializer;
  logic clk = 0, rst = 0, start = 0, hold_busy = 0;
  logic [3:0] matrix_size = 0;
  logic [3:0] rd_addr;
  logic [31:0] rd_data;
  logic tx_busy, tx_start, busy, done, ubusy;
  logic [7:0] tx_data;
  logic [31:0] mem [16];
  int ack_cnt, bsy_cnt;
  int checks = 0, errors = 0;
  int n_tx = 0, done_cnt = 0, base_tx = 0, base_done = 0;
  logic [7:0] exp_q [$];
  logic [7:0] log_q [$];
  bit seen_addr [16];
  logic hs = 0, seen_b = 0, prev_done = 0;
  logic [7:0] hs_data;

  result_serializer dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  // UART: acknowledges 3 cycles after tx_start, then stays busy for 5 cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_cnt <= 0;
      bsy_cnt <= 0;
      ubusy <= 1'b0;
    end else if (tx_start) begin
      ack_cnt <= 3;
    end else if (ack_cnt != 0) begin
      ack_cnt <= ack_cnt - 1;
      if (ack_cnt == 1) begin
        ubusy <= 1'b1;
        bsy_cnt <= 5;
      end
    end else if (bsy_cnt != 0) begin
      bsy_cnt <= bsy_cnt - 1;
      if (bsy_cnt == 1) ubusy <= 1'b0;
    end
  end
  assign tx_busy = ubusy | hold_busy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // compare process: every sent byte against the model, data stability, busy after done
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      hs = 0;
      prev_done = 0;
    end else begin
      if (tx_start) begin
        n_tx++;
        log_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra: byte %0h sent while none expected", tx_data);
        end else check("tx_byte", tx_data, exp_q.pop_front());
        hs = 1;
        seen_b = 0;
        hs_data = tx_data;
      end else if (hs) begin
        check("tx_stable", tx_data, hs_data);
        if (tx_busy) seen_b = 1;
        else if (seen_b) hs = 0;
      end
      if (prev_done) check("busy_after_done", busy, 0);
      if (done) done_cnt++;
      prev_done = done;
      if (busy) seen_addr[rd_addr] = 1;
    end
  end

  task automatic start_frame(input logic [3:0] ms);
    int n = ms > 4 ? 4 : int'(ms);
    exp_q.delete();
    log_q.delete();
    for (int w = 0; w < n * n; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((mem[w] >> (8 * (3 - b))) & 32'hff));
    base_tx = n_tx;
    base_done = done_cnt;
    matrix_size = ms;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_frame(input string nm, input int nbytes);
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base_done) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen within 5000 cycles", nm);
    end
    repeat (3) @(negedge clk);
    #1;
    check({nm, "_bytes"}, n_tx - base_tx, nbytes);
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_done"}, done_cnt - base_done, 1);
  endtask

  task automatic load_spec_mem();
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h99AABBCC;
    mem[3] = 32'hDDEEFF00;
    for (int i = 4; i < 16; i++) mem[i] = 32'hDEAD0000 | i;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ok;
    load_spec_mem();
    repeat (3) @(negedge clk);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    // start raised together with reset release: accepted on the first edge
    rst = 1;
    start_frame(4'd2);
    check("accept_first_edge", busy, 1);
    finish_frame("n2", 16);
    check("n2_b0", log_q[0], 8'h11);
    check("n2_b3", log_q[3], 8'h44);
    check("n2_b4", log_q[4], 8'h55);
    check("n2_b15", log_q[15], 8'h00);

    // N=0: straight to FIN, done in the cycle after acceptance
    base_tx = n_tx;
    matrix_size = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    check("n0_done", done, 1);
    check("n0_busy", busy, 1);
    @(negedge clk);
    check("n0_done_clr", done, 0);
    check("n0_busy_clr", busy, 0);
    repeat (5) @(negedge clk);
    check("n0_no_tx", n_tx - base_tx, 0);

    // matrix_size=7 clamps to 4: all 16 words, 64 bytes
    for (int i = 0; i < 16; i++) begin
      mem[i] = {8'(i), ~8'(i), 8'hA0 | 8'(i), 8'h5A};
      seen_addr[i] = 0;
    end
    start_frame(4'd7);
    finish_frame("n7", 64);
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += seen_addr[i] ? 1 : 0;
    check("n7_addrs", cnt, 16);
    check("n7_b60", log_q[60], 8'h0F);
    check("n7_b62", log_q[62], 8'hAF);

    // UART held busy for 50 cycles before the first byte
    hold_busy = 1;
    start_frame(4'd2);
    repeat (50) @(negedge clk);
    #1;
    check("hold_no_tx", n_tx - base_tx, 0);
    check("hold_busy", busy, 1);
    hold_busy = 0;
    finish_frame("hold", 16);

    // second start while busy is ignored
    start_frame(4'd1);
    repeat (5) @(negedge clk);
    check("restart_busy", busy, 1);
    matrix_size = 4'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    finish_frame("ignore", 4);
    check("ignore_b1", log_q[1], 8'hFF);

    // reset in the middle of byte 2 of word 1, then a clean restart
    load_spec_mem();
    start_frame(4'd2);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (n_tx - base_tx >= 6) ok = 1;
    end
    check("mid_reached", ok, 1);
    check("mid_byte", log_q[5], 8'h66);
    #2 rst = 0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1;
    start_frame(4'd2);
    finish_frame("after_rst", 16);
    check("after_rst_b0", log_q[0], 8'h11);
    check("after_rst_b15", log_q[15], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32: width of one result word; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4: result memory address width, giving 16 entries.
REQ-003 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to transmit the result matrix.
REQ-006 SHALL have port matrix_size, input, 4: matrix dimension N, sampled at accepted start.
REQ-007 SHALL have port rd_addr, output, ADDR_W: result memory read address.
REQ-008 SHALL have port rd_data, input, WORD_W: result memory read data, valid one cycle after rd_addr.
REQ-009 SHALL have port tx_busy, input, 1: UART transmitter busy, sourced from a slower baud clock.
REQ-010 SHALL have port tx_data, output, 8: byte presented to the UART transmitter.
REQ-011 SHALL have port tx_start, output, 1: one-cycle pulse requesting transmission of tx_data.
REQ-012 SHALL have port busy, output, 1: high from accepted start until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the frame is complete.

Function
REQ-014 SHALL use states IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_TXD, NEXT, FIN.
REQ-015 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-016 SHALL latch N = min(matrix_size, 4) at start; word count SHALL be N*N (max 16).
REQ-017 SHALL go IDLE->FIN directly when N=0, sending no bytes.
REQ-018 READ SHALL drive rd_addr with the word index (0 first, row-major); LATCH SHALL capture rd_data into a WORD_W shift register one cycle later.
REQ-019 SHALL send each word as WORD_W/8 bytes, most significant byte first.
REQ-020 SEND SHALL wait while tx_busy=1; when tx_busy=0 it SHALL drive tx_data and pulse tx_start for exactly one clk cycle, then enter WAIT_ACK.
REQ-021 WAIT_ACK SHALL hold until tx_busy=1, then enter WAIT_TXD; WAIT_TXD SHALL hold until tx_busy=0.
REQ-022 tx_data SHALL stay stable from the tx_start pulse until WAIT_TXD exits.
REQ-023 After the last byte of a word, NEXT SHALL increment the word index; if index=N*N it SHALL enter FIN, else READ.
REQ-024 After a non-last byte, WAIT_TXD exit SHALL shift the register left by 8 and return to SEND.
REQ-025 FIN SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-026 rd_addr SHALL hold its last value outside READ; the index SHALL never wrap past 2^ADDR_W-1.
REQ-027 busy SHALL be 1 in every state except IDLE and SHALL be 0 in the cycle after done.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, regardless of clk, from any state including mid-byte.
REQ-029 Reset values SHALL be: rd_addr=0, tx_data=0, tx_start=0, busy=0, done=0, word index=0, byte count=0, shift register=0.
REQ-030 After reset release, the first clk edge SHALL see IDLE, and start SHALL be accepted on that edge.

Verification
REQ-031 N=2, memory {0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00}, UART model with 3-cycle ack delay -> bytes 11,22,33,44,55,...,FF,00 in order (16 tx_start pulses), then one done pulse.
REQ-032 matrix_size=0, start -> done one cycle after start acceptance; no tx_start, busy high for at most 2 cycles.
REQ-033 matrix_size=7 -> clamped to N=4: 64 bytes sent, rd_addr covering 0..15, done once.
REQ-034 tx_busy held 1 for 50 cycles before the first byte -> no tx_start until tx_busy falls; tx_data stable through the handshake.
REQ-035 Second start pulsed while busy=1 -> ignored; byte count unchanged.
REQ-036 rst=0 asserted during byte 2 of word 1 -> all outputs zero asynchronously; a new start after release restarts at rd_addr=0.
